// File: rtl/pong_renderer_pkg.sv
// rtl/pong_renderer_pkg.sv - shared VGA timing defaults and colour constants
package pong_renderer_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // {R,G,B}
    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_WHITE = 3'b111;

endpackage

// File: rtl/pong_vga_timing.sv
// rtl/pong_vga_timing.sv - stage-0 pixel/line counters with active and sync decode
module pong_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [CW-1:0] o_hc,
    output logic [CW-1:0] o_vc,
    output logic          o_active,
    output logic          o_hsync_n,
    output logic          o_vsync_n,
    output logic          o_frame_first,
    output logic          o_frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_hc == CW'(H_TOTAL - 1));
    assign w_v_last = (r_vc == CW'(V_TOTAL - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : r_vc + CW'(1);
        end else begin
            r_hc <= r_hc + CW'(1);
        end
    end

    assign o_hc          = r_hc;
    assign o_vc          = r_vc;
    assign o_active      = (r_hc < CW'(H_ACTIVE)) && (r_vc < CW'(V_ACTIVE));
    assign o_hsync_n     = !((r_hc >= CW'(H_ACTIVE + H_FP)) && (r_hc < CW'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vsync_n     = !((r_vc >= CW'(V_ACTIVE + V_FP)) && (r_vc < CW'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_frame_first = (r_hc == '0) && (r_vc == '0);
    assign o_frame_last  = w_h_last && w_v_last;

endmodule

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - ball and paddle renderer with frame-latched coordinates and registered VGA outputs
module pong_renderer
    import pong_renderer_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int CW        = 10,
    parameter int BALL_SIZE = 10,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 48,
    parameter int PAD_L_X   = 16,
    parameter int PAD_R_X   = 616
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] ball_pos_x,
    input  logic [CW-1:0] ball_pos_y,
    input  logic [CW-1:0] paddle_l_y,
    input  logic [CW-1:0] paddle_r_y,
    output logic          R,
    output logic          G,
    output logic          B,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          frame_start
);

    // One spare bit so that coordinate + size can never wrap back into view.
    localparam int XW = CW + 1;

    logic [CW-1:0] w_hc;
    logic [CW-1:0] w_vc;
    logic          w_active;
    logic          w_hsync_n;
    logic          w_vsync_n;
    logic          w_frame_first;
    logic          w_frame_last;

    pong_vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .o_hc          (w_hc),
        .o_vc          (w_vc),
        .o_active      (w_active),
        .o_hsync_n     (w_hsync_n),
        .o_vsync_n     (w_vsync_n),
        .o_frame_first (w_frame_first),
        .o_frame_last  (w_frame_last)
    );

    logic [CW-1:0] r_ball_x;
    logic [CW-1:0] r_ball_y;
    logic [CW-1:0] r_pad_l_y;
    logic [CW-1:0] r_pad_r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ball_x  <= '0;
            r_ball_y  <= '0;
            r_pad_l_y <= '0;
            r_pad_r_y <= '0;
        end else if (w_frame_last) begin
            r_ball_x  <= ball_pos_x;
            r_ball_y  <= ball_pos_y;
            r_pad_l_y <= paddle_l_y;
            r_pad_r_y <= paddle_r_y;
        end
    end

    function automatic logic in_span(input logic [XW-1:0] pos, input logic [XW-1:0] lo, input int len);
        return (pos >= lo) && (pos < lo + XW'(len));
    endfunction

    logic [XW-1:0] w_x;
    logic [XW-1:0] w_y;
    logic          w_ball;
    logic          w_pad_l;
    logic          w_pad_r;
    logic [2:0]    w_rgb;

    assign w_x     = {1'b0, w_hc};
    assign w_y     = {1'b0, w_vc};
    assign w_ball  = in_span(w_x, {1'b0, r_ball_x}, BALL_SIZE) && in_span(w_y, {1'b0, r_ball_y}, BALL_SIZE);
    assign w_pad_l = in_span(w_x, XW'(PAD_L_X), PAD_W) && in_span(w_y, {1'b0, r_pad_l_y}, PAD_H);
    assign w_pad_r = in_span(w_x, XW'(PAD_R_X), PAD_W) && in_span(w_y, {1'b0, r_pad_r_y}, PAD_H);

    always_comb begin
        w_rgb = COL_BLACK;
        if (w_active) begin
            if (w_ball) begin
                w_rgb = COL_RED;
            end else if (w_pad_l || w_pad_r) begin
                w_rgb = COL_WHITE;
            end
        end
    end

    logic [2:0] r_rgb;
    logic       r_hsync_n;
    logic       r_vsync_n;
    logic       r_frame_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb         <= COL_BLACK;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb;
            r_hsync_n     <= w_hsync_n;
            r_vsync_n     <= w_vsync_n;
            r_frame_start <= w_frame_first;
        end
    end

    assign R           = r_rgb[2];
    assign G           = r_rgb[1];
    assign B           = r_rgb[0];
    assign vga_h_sync  = r_hsync_n;
    assign vga_v_sync  = r_vsync_n;
    assign frame_start = r_frame_start;

endmodule
